// File: rtl/opfetch_pkg.sv
// Shared constants for the operand fetch stage: opcodes, class masks,
// instruction field positions and the hard-wired zero register.
package opfetch_pkg;

    localparam int unsigned OPF_DATA_W   = 32;
    localparam int unsigned OPF_REG_AW   = 5;
    localparam int unsigned OPF_ZERO_REG = 31;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned OPCODE_W     = 6;
    localparam int unsigned LIT_W        = 16;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] OP_LDR = 6'h1F;

    // opcode[5:4] selects the ALU class: 2'b10 register form, 2'b11 literal form
    localparam logic [5:0] CLASS_MASK = 6'h30;
    localparam logic [5:0] CLASS_OP   = 6'h20;
    localparam logic [5:0] CLASS_OPC  = 6'h30;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned RC_HI  = 25;
    localparam int unsigned RC_LO  = 21;
    localparam int unsigned RA_HI  = 20;
    localparam int unsigned RA_LO  = 16;
    localparam int unsigned RB_HI  = 15;
    localparam int unsigned RB_LO  = 11;
    localparam int unsigned LIT_HI = 15;
    localparam int unsigned LIT_LO = 0;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_OP    = 2'd1,
        CLS_OPC   = 2'd2
    } opclass_e;

    function automatic opclass_e op_class(input logic [5:0] opcode);
        case (opcode & CLASS_MASK)
            CLASS_OP:  op_class = CLS_OP;
            CLASS_OPC: op_class = CLS_OPC;
            default:   op_class = CLS_OTHER;
        endcase
    endfunction

    function automatic logic is_pc_relative(input logic [5:0] opcode);
        case (opcode)
            OP_JMP, OP_BEQ, OP_BNE, OP_LDR: is_pc_relative = 1'b1;
            default:                        is_pc_relative = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// One register-read port: EX > MEM > WB > register file priority, with R31 pinned to 0.
// Forwarding is compiled in only when OPFETCH_BYPASS_EN is defined.
module operand_bypass_mux #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rf_dat,
    input  logic              i_ex_en,
    input  logic [REG_AW-1:0] i_ex_add,
    input  logic [DATA_W-1:0] i_ex_dat,
    input  logic              i_mem_en,
    input  logic [REG_AW-1:0] i_mem_add,
    input  logic [DATA_W-1:0] i_mem_dat,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_wb_add,
    input  logic [DATA_W-1:0] i_wb_dat,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_ex_match,
    output logic              o_mem_match,
    output logic              o_wb_match
);

    logic [REG_AW-1:0] w_zero_addr;
    logic              w_is_zero;

    assign w_zero_addr = REG_AW'(ZERO_REG);
    assign w_is_zero   = (i_addr == w_zero_addr);

    // The zero register never matches a producer, so it also never causes a stall
    assign o_ex_match  = i_ex_en  & ~w_is_zero & (i_ex_add  == i_addr);
    assign o_mem_match = i_mem_en & ~w_is_zero & (i_mem_add == i_addr);
    assign o_wb_match  = i_wb_en  & ~w_is_zero & (i_wb_add  == i_addr);

`ifdef OPFETCH_BYPASS_EN
    // Youngest in-flight producer wins; WB covers the same-edge register file write
    always_comb begin
        o_dat = i_rf_dat;
        if (w_is_zero) begin
            o_dat = {DATA_W{1'b0}};
        end else if (o_ex_match) begin
            o_dat = i_ex_dat;
        end else if (o_mem_match) begin
            o_dat = i_mem_dat;
        end else if (o_wb_match) begin
            o_dat = i_wb_dat;
        end else begin
            o_dat = i_rf_dat;
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{i_ex_dat, i_mem_dat, i_wb_dat};

    // Without forwarding the stage stalls on any match, so only the file is read
    always_comb begin
        o_dat = i_rf_dat;
        if (w_is_zero) begin
            o_dat = {DATA_W{1'b0}};
        end else begin
            o_dat = i_rf_dat;
        end
    end
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/register-read stage feeding the ID/EX register with hazard stall and flush.
// OPFETCH_BYPASS_EN enables EX/MEM/WB forwarding; otherwise any in-flight match stalls.
module operand_fetch_stage
    import opfetch_pkg::*;
#(
    parameter int unsigned DATA_W   = OPF_DATA_W,
    parameter int unsigned REG_AW   = OPF_REG_AW,
    parameter int unsigned ZERO_REG = OPF_ZERO_REG
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                if_valid_i,
    input  logic [INSTR_W-1:0]  if_instr_i,
    input  logic [DATA_W-1:0]   if_pc_i,
    output logic                if_ready_o,
    input  logic                flush_i,
    output logic [REG_AW-1:0]   rf_a_add_o,
    output logic [REG_AW-1:0]   rf_b_add_o,
    input  logic [DATA_W-1:0]   rf_a_dat_i,
    input  logic [DATA_W-1:0]   rf_b_dat_i,
    input  logic                ex_fwd_en_i,
    input  logic [REG_AW-1:0]   ex_fwd_add_i,
    input  logic [DATA_W-1:0]   ex_fwd_dat_i,
    input  logic                ex_is_load_i,
    input  logic                mem_fwd_en_i,
    input  logic [REG_AW-1:0]   mem_fwd_add_i,
    input  logic [DATA_W-1:0]   mem_fwd_dat_i,
    input  logic                wb_fwd_en_i,
    input  logic [REG_AW-1:0]   wb_fwd_add_i,
    input  logic [DATA_W-1:0]   wb_fwd_dat_i,
    input  logic                ex_ready_i,
    output logic                ex_valid_o,
    output logic [DATA_W-1:0]   ex_pc_o,
    output logic [OPCODE_W-1:0] ex_opcode_o,
    output logic [REG_AW-1:0]   ex_rc_o,
    output logic [DATA_W-1:0]   ex_op_a_o,
    output logic [DATA_W-1:0]   ex_op_b_o,
    output logic [DATA_W-1:0]   ex_st_dat_o
);

    logic [OPCODE_W-1:0] w_opcode;
    logic [REG_AW-1:0]   w_rc;
    logic [REG_AW-1:0]   w_ra;
    logic [REG_AW-1:0]   w_rb;
    logic [LIT_W-1:0]    w_lit;
    opclass_e            w_cls;
    logic                w_is_st;
    logic                w_is_ld;
    logic                w_use_b;
    logic                w_lit_sel;
    logic [DATA_W-1:0]   w_lit_sext;
    logic [REG_AW-1:0]   w_zero_addr;

    logic [DATA_W-1:0]   w_a_dat;
    logic [DATA_W-1:0]   w_b_dat;
    logic                w_ex_match_a;
    logic                w_mem_match_a;
    logic                w_wb_match_a;
    logic                w_ex_match_b;
    logic                w_mem_match_b;
    logic                w_wb_match_b;

    logic                w_hazard;
    logic                w_advance;
    logic                w_take;
    logic [DATA_W-1:0]   w_op_b;

    logic                r_ex_valid;
    logic [DATA_W-1:0]   r_ex_pc;
    logic [OPCODE_W-1:0] r_ex_opcode;
    logic [REG_AW-1:0]   r_ex_rc;
    logic [DATA_W-1:0]   r_ex_op_a;
    logic [DATA_W-1:0]   r_ex_op_b;
    logic [DATA_W-1:0]   r_ex_st_dat;

    assign w_opcode    = if_instr_i[OPC_HI:OPC_LO];
    assign w_rc        = if_instr_i[RC_HI:RC_LO];
    assign w_ra        = if_instr_i[RA_HI:RA_LO];
    assign w_rb        = if_instr_i[RB_HI:RB_LO];
    assign w_lit       = if_instr_i[LIT_HI:LIT_LO];
    assign w_cls       = op_class(w_opcode);
    assign w_is_st     = (w_opcode == OP_ST);
    assign w_is_ld     = (w_opcode == OP_LD);
    assign w_use_b     = (w_cls == CLS_OP) | w_is_st;
    assign w_lit_sel   = (w_cls == CLS_OPC) | w_is_ld | w_is_st;
    assign w_lit_sext  = {{(DATA_W-LIT_W){w_lit[LIT_W-1]}}, w_lit};
    assign w_zero_addr = REG_AW'(ZERO_REG);

    // Stores read rc on port B so its value can travel as store data
    assign rf_a_add_o = w_ra;
    assign rf_b_add_o = w_is_st ? w_rc : w_rb;

    operand_bypass_mux #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_bypass_a (
        .i_addr      (rf_a_add_o),
        .i_rf_dat    (rf_a_dat_i),
        .i_ex_en     (ex_fwd_en_i),
        .i_ex_add    (ex_fwd_add_i),
        .i_ex_dat    (ex_fwd_dat_i),
        .i_mem_en    (mem_fwd_en_i),
        .i_mem_add   (mem_fwd_add_i),
        .i_mem_dat   (mem_fwd_dat_i),
        .i_wb_en     (wb_fwd_en_i),
        .i_wb_add    (wb_fwd_add_i),
        .i_wb_dat    (wb_fwd_dat_i),
        .o_dat       (w_a_dat),
        .o_ex_match  (w_ex_match_a),
        .o_mem_match (w_mem_match_a),
        .o_wb_match  (w_wb_match_a)
    );

    operand_bypass_mux #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_bypass_b (
        .i_addr      (rf_b_add_o),
        .i_rf_dat    (rf_b_dat_i),
        .i_ex_en     (ex_fwd_en_i),
        .i_ex_add    (ex_fwd_add_i),
        .i_ex_dat    (ex_fwd_dat_i),
        .i_mem_en    (mem_fwd_en_i),
        .i_mem_add   (mem_fwd_add_i),
        .i_mem_dat   (mem_fwd_dat_i),
        .i_wb_en     (wb_fwd_en_i),
        .i_wb_add    (wb_fwd_add_i),
        .i_wb_dat    (wb_fwd_dat_i),
        .o_dat       (w_b_dat),
        .o_ex_match  (w_ex_match_b),
        .o_mem_match (w_mem_match_b),
        .o_wb_match  (w_wb_match_b)
    );

`ifdef OPFETCH_BYPASS_EN
    logic w_unused_match;
    assign w_unused_match = ^{w_mem_match_a, w_wb_match_a, w_mem_match_b, w_wb_match_b};

    // Only a load in EX has no forwardable result yet; port A is used by every opcode
    assign w_hazard = ex_fwd_en_i & ex_is_load_i & (ex_fwd_add_i != w_zero_addr)
                    & (w_ex_match_a | (w_use_b & w_ex_match_b));
`else
    logic w_unused_ld;
    assign w_unused_ld = ex_is_load_i;

    assign w_hazard = (w_ex_match_a | w_mem_match_a | w_wb_match_a)
                    | (w_use_b & (w_ex_match_b | w_mem_match_b | w_wb_match_b));
`endif

    assign w_advance  = ~r_ex_valid | ex_ready_i;
    assign if_ready_o = flush_i ? w_advance : (w_advance & ~w_hazard);
    assign w_take     = if_valid_i & ~w_hazard;
    assign w_op_b     = w_lit_sel ? w_lit_sext : w_b_dat;

    // ID/EX register: flush kills even a held entry; payload loads only with a live instruction
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ex_valid  <= 1'b0;
            r_ex_pc     <= {DATA_W{1'b0}};
            r_ex_opcode <= {OPCODE_W{1'b0}};
            r_ex_rc     <= {REG_AW{1'b0}};
            r_ex_op_a   <= {DATA_W{1'b0}};
            r_ex_op_b   <= {DATA_W{1'b0}};
            r_ex_st_dat <= {DATA_W{1'b0}};
        end else if (flush_i) begin
            r_ex_valid <= 1'b0;
        end else if (w_advance) begin
            r_ex_valid <= w_take;
            if (w_take) begin
                r_ex_pc     <= if_pc_i;
                r_ex_opcode <= w_opcode;
                r_ex_rc     <= w_rc;
                r_ex_op_a   <= w_a_dat;
                r_ex_op_b   <= w_op_b;
                r_ex_st_dat <= w_b_dat;
            end
        end
    end

    assign ex_valid_o  = r_ex_valid;
    assign ex_pc_o     = r_ex_pc;
    assign ex_opcode_o = r_ex_opcode;
    assign ex_rc_o     = r_ex_rc;
    assign ex_op_a_o   = r_ex_op_a;
    assign ex_op_b_o   = r_ex_op_b;
    assign ex_st_dat_o = r_ex_st_dat;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed cases then random traffic,
// checked against a rule-level model that follows OPFETCH_BYPASS_EN like the DUT.
module tb_operand_fetch_stage;

    localparam logic [5:0] T_LD   = 6'h18;
    localparam logic [5:0] T_ST   = 6'h19;
    localparam logic [5:0] T_ADD  = 6'h20;
    localparam logic [5:0] T_ADDC = 6'h30;

    logic        clk_i, rst_n_i;
    logic        if_valid_i, if_ready_o, flush_i, ex_ready_i, ex_valid_o;
    logic [31:0] if_instr_i, if_pc_i, rf_a_dat_i, rf_b_dat_i;
    logic [4:0]  rf_a_add_o, rf_b_add_o, ex_fwd_add_i, mem_fwd_add_i, wb_fwd_add_i, ex_rc_o;
    logic        ex_fwd_en_i, ex_is_load_i, mem_fwd_en_i, wb_fwd_en_i;
    logic [31:0] ex_fwd_dat_i, mem_fwd_dat_i, wb_fwd_dat_i;
    logic [31:0] ex_pc_o, ex_op_a_o, ex_op_b_o, ex_st_dat_o;
    logic [5:0]  ex_opcode_o;

    operand_fetch_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
        .if_pc_i(if_pc_i), .if_ready_o(if_ready_o), .flush_i(flush_i),
        .rf_a_add_o(rf_a_add_o), .rf_b_add_o(rf_b_add_o), .rf_a_dat_i(rf_a_dat_i),
        .rf_b_dat_i(rf_b_dat_i), .ex_fwd_en_i(ex_fwd_en_i), .ex_fwd_add_i(ex_fwd_add_i),
        .ex_fwd_dat_i(ex_fwd_dat_i), .ex_is_load_i(ex_is_load_i), .mem_fwd_en_i(mem_fwd_en_i),
        .mem_fwd_add_i(mem_fwd_add_i), .mem_fwd_dat_i(mem_fwd_dat_i), .wb_fwd_en_i(wb_fwd_en_i),
        .wb_fwd_add_i(wb_fwd_add_i), .wb_fwd_dat_i(wb_fwd_dat_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_opcode_o(ex_opcode_o), .ex_rc_o(ex_rc_o),
        .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o), .ex_st_dat_o(ex_st_dat_o)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        flush;
        logic        ex_ready;
        logic        ex_en;
        logic        ex_ld;
        logic [4:0]  ex_add;
        logic [31:0] ex_dat;
        logic        mem_en;
        logic [4:0]  mem_add;
        logic [31:0] mem_dat;
        logic        wb_en;
        logic [4:0]  wb_add;
        logic [31:0] wb_dat;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic        is_st;
    } exp_t;

    logic [31:0] regs [32];
    exp_t        q [$];
    bit          m_valid;
    int          n_pass, n_total;
    logic [5:0]  ops [11];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Register file model: R31 holds garbage so the stage must zero it itself
    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 31) ? 32'hBAD0_BAD0 : 32'h0000_0100 * i + 32'h0000_00A5;
        end else if (wb_fwd_en_i && wb_fwd_add_i != 5'd31) begin
            regs[wb_fwd_add_i] <= wb_fwd_dat_i;
        end
    end

    assign rf_a_dat_i = regs[rf_a_add_o];
    assign rf_b_dat_i = regs[rf_b_add_o];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ex_ready = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rc, input logic [4:0] ra,
                                        input logic [15:0] lo);
        return {op, rc, ra, lo};
    endfunction

    function automatic logic [4:0] rreg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    // Architectural value of a register as seen by the instruction this cycle
    function automatic logic [31:0] val(input stim_t s, input logic [4:0] a);
        if (a == 5'd31) return 32'h0;
`ifdef OPFETCH_BYPASS_EN
        if (s.ex_en && s.ex_add == a) return s.ex_dat;
        if (s.mem_en && s.mem_add == a) return s.mem_dat;
        if (s.wb_en && s.wb_add == a) return s.wb_dat;
`endif
        return regs[a];
    endfunction

    function automatic bit busy(input stim_t s, input logic [4:0] a);
        if (a == 5'd31) return 1'b0;
        return (s.ex_en && s.ex_add == a) || (s.mem_en && s.mem_add == a) || (s.wb_en && s.wb_add == a);
    endfunction

    task automatic drive(input stim_t s);
        if_valid_i = s.valid;  if_instr_i = s.instr;  if_pc_i = s.pc;
        flush_i = s.flush;     ex_ready_i = s.ex_ready;
        ex_fwd_en_i = s.ex_en; ex_is_load_i = s.ex_ld; ex_fwd_add_i = s.ex_add; ex_fwd_dat_i = s.ex_dat;
        mem_fwd_en_i = s.mem_en; mem_fwd_add_i = s.mem_add; mem_fwd_dat_i = s.mem_dat;
        wb_fwd_en_i = s.wb_en; wb_fwd_add_i = s.wb_add; wb_fwd_dat_i = s.wb_dat;
    endtask

    task automatic step(input stim_t s);
        logic [5:0] op;
        logic [4:0] rc, ra, rb, ba;
        bit         is_st, use_b, lit, hz, adv, rdy;
        exp_t       e;
        @(posedge clk_i);
        #2;
        drive(s);
        #1;
        op = s.instr[31:26]; rc = s.instr[25:21]; ra = s.instr[20:16]; rb = s.instr[15:11];
        is_st = (op == T_ST);
        use_b = (op[5:4] == 2'b10) || is_st;
        lit   = (op[5:4] == 2'b11) || (op == T_LD) || is_st;
        ba    = is_st ? rc : rb;
`ifdef OPFETCH_BYPASS_EN
        hz = s.ex_en && s.ex_ld && s.ex_add != 5'd31 && (s.ex_add == ra || (use_b && s.ex_add == ba));
`else
        hz = busy(s, ra) || (use_b && busy(s, ba));
`endif
        adv = !m_valid || s.ex_ready;
        rdy = s.flush ? adv : (adv && !hz);
        chk("if_ready", {31'b0, if_ready_o}, {31'b0, rdy});
        chk("ex_valid", {31'b0, ex_valid_o}, {31'b0, m_valid});
        chk("rf_a_add", {27'b0, rf_a_add_o}, {27'b0, ra});
        chk("rf_b_add", {27'b0, rf_b_add_o}, {27'b0, ba});
        if (s.flush) begin
            if (m_valid && !s.ex_ready && q.size() > 0) q.delete(q.size() - 1);
            m_valid = 1'b0;
        end else if (adv) begin
            m_valid = s.valid && !hz;
            if (m_valid) begin
                e.pc = s.pc; e.op = op; e.rc = rc; e.a = val(s, ra);
                e.b = lit ? {{16{s.instr[15]}}, s.instr[15:0]} : val(s, ba);
                e.st = val(s, rc); e.is_st = is_st;
                q.push_back(e);
            end
        end
    endtask

    task automatic reset_cycle(input stim_t s);
        @(posedge clk_i);
        #2;
        drive(s);
        rst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        q.delete();
        m_valid = 1'b0;
        chk("rst_valid", {31'b0, ex_valid_o}, 32'h0);
        chk("rst_pc", ex_pc_o, 32'h0);
        chk("rst_opcode", {26'b0, ex_opcode_o}, 32'h0);
        chk("rst_rc", {27'b0, ex_rc_o}, 32'h0);
        chk("rst_op_a", ex_op_a_o, 32'h0);
        chk("rst_op_b", ex_op_b_o, 32'h0);
        chk("rst_st", ex_st_dat_o, 32'h0);
        chk("rst_if_ready", {31'b0, if_ready_o}, 32'h1);
        #1;
        drive(idle());
        rst_n_i = 1'b1;
    endtask

    // Monitor: every consumed ID/EX entry must match the oldest expected one
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i === 1'b1 && ex_valid_o === 1'b1 && ex_ready_i === 1'b1) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_out: got valid pc %h expected no entry", ex_pc_o);
                end else begin
                    e = q.pop_front();
                    chk("out_pc", ex_pc_o, e.pc);
                    chk("out_opcode", {26'b0, ex_opcode_o}, {26'b0, e.op});
                    chk("out_rc", {27'b0, ex_rc_o}, {27'b0, e.rc});
                    chk("out_op_a", ex_op_a_o, e.a);
                    chk("out_op_b", ex_op_b_o, e.b);
                    if (e.is_st) chk("out_st_dat", ex_st_dat_o, e.st);
                end
            end
        end
    end

    initial begin
        stim_t s;
        n_pass = 0; n_total = 0; m_valid = 1'b0;
        ops = '{T_LD, T_ST, 6'h1B, 6'h1C, 6'h1D, 6'h1F, T_ADD, 6'h23, T_ADDC, 6'h35, 6'h02};
        rst_n_i = 1'b0;
        drive(idle());
        reset_cycle(idle());

        s = idle(); s.wb_en = 1'b1; s.wb_add = 5'd1; s.wb_dat = 32'd5; step(s);
        s = idle(); s.wb_en = 1'b1; s.wb_add = 5'd2; s.wb_dat = 32'd7; step(s);
        s = idle(); s.valid = 1'b1; s.pc = 32'h100; s.instr = ins(T_ADD, 5'd3, 5'd1, {5'd2, 11'd0}); step(s);
        s = idle(); s.valid = 1'b1; s.pc = 32'h104; s.instr = ins(T_ADDC, 5'd5, 5'd4, 16'hFFFC); step(s);
        s = idle(); s.valid = 1'b1; s.pc = 32'h108; s.instr = ins(T_ADD, 5'd6, 5'd31, {5'd31, 11'd0});
        s.ex_en = 1'b1; s.ex_add = 5'd31; s.ex_dat = 32'hDEAD; step(s);
        // Forwarding priority on port A, peeling producers off one at a time
        for (int k = 0; k < 3; k++) begin
            s = idle(); s.valid = 1'b1; s.pc = 32'h200 + 32'(k); s.instr = ins(T_ADDC, 5'd7, 5'd6, 16'h0);
            s.ex_en = (k == 0); s.ex_add = 5'd6; s.ex_dat = 32'h11;
            s.mem_en = (k <= 1); s.mem_add = 5'd6; s.mem_dat = 32'h22;
            s.wb_en = 1'b1; s.wb_add = 5'd6; s.wb_dat = 32'h33;
            step(s);
        end
        // Load-use on r8 then the loaded value arrives from MEM
        s = idle(); s.valid = 1'b1; s.pc = 32'h300; s.instr = ins(T_ADD, 5'd9, 5'd8, {5'd0, 11'd0});
        s.ex_en = 1'b1; s.ex_ld = 1'b1; s.ex_add = 5'd8; s.ex_dat = 32'hFFFF; step(s);
        s.ex_en = 1'b0; s.ex_ld = 1'b0; s.mem_en = 1'b1; s.mem_add = 5'd8; s.mem_dat = 32'h88; step(s);
        s.mem_en = 1'b0; s.wb_en = 1'b1; s.wb_add = 5'd8; s.wb_dat = 32'h88; step(s);
        // Flush against a held entry
        s = idle(); s.valid = 1'b1; s.pc = 32'h400; s.instr = ins(T_ADD, 5'd1, 5'd2, {5'd3, 11'd0}); step(s);
        s.pc = 32'h404; s.ex_ready = 1'b0; s.flush = 1'b1; step(s);
        step(idle());
        // Dependent ADD walking its producer through EX, MEM and WB
        s = idle(); s.valid = 1'b1; s.pc = 32'h500; s.instr = ins(T_ADD, 5'd10, 5'd9, {5'd0, 11'd0});
        s.ex_en = 1'b1; s.ex_add = 5'd9; s.ex_dat = 32'h99; step(s);
        s.ex_en = 1'b0; s.mem_en = 1'b1; s.mem_add = 5'd9; s.mem_dat = 32'h99; step(s);
        s.mem_en = 1'b0; s.wb_en = 1'b1; s.wb_add = 5'd9; s.wb_dat = 32'h99; step(s);
        s.wb_en = 1'b0; step(s);

        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.valid = ($urandom_range(0, 9) < 8);
            s.instr = {ops[$urandom_range(0, 10)], rreg(), rreg(), rreg(), 11'($urandom)};
            s.pc = $urandom;
            s.flush = ($urandom_range(0, 19) == 0);
            s.ex_ready = ($urandom_range(0, 9) < 7);
            s.ex_en = ($urandom_range(0, 2) == 0); s.ex_ld = 1'($urandom);
            s.ex_add = rreg(); s.ex_dat = $urandom;
            s.mem_en = ($urandom_range(0, 2) == 0); s.mem_add = rreg(); s.mem_dat = $urandom;
            s.wb_en = ($urandom_range(0, 2) == 0); s.wb_add = rreg(); s.wb_dat = $urandom;
            step(s);
        end

        repeat (3) step(idle());
        chk("drain_empty", 32'(q.size()), 32'h0);

        // Reset in the middle of a held, valid entry
        s = idle(); s.valid = 1'b1; s.pc = 32'h600; s.instr = ins(T_ADD, 5'd1, 5'd2, {5'd3, 11'd0}); step(s);
        s.ex_ready = 1'b0; s.pc = 32'h604; step(s);
        reset_cycle(s);
        step(idle());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
